// File: rtl/painel_de_pedidos.sv
// painel_de_pedidos: order FIFO and dispenser supervisor checking dose, hangs and totals
module painel_de_pedidos #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 16,
  parameter int ML_PER_TICK = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pedido_valid,
  input  logic [1:0]               pedido_tipo,
  output logic                     pedido_ready,
  output logic [1:0]               tipo,
  input  logic                     C,
  input  logic                     L,
  input  logic                     F,
  output logic                     ocupado,
  output logic                     entregue,
  output logic                     erro,
  output logic [1:0]               erro_codigo,
  output logic [7:0]               ml_cafe,
  output logic [7:0]               ml_leite,
  output logic [15:0]              total_servidos,
  output logic [$clog2(DEPTH):0]   nivel
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] SERVINDO = 2'd1;
  localparam logic [1:0] PAUSA    = 2'd2;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    estado, atual, head;
  logic [3:0]    cafe_ticks, leite_ticks, exp_c, exp_l;
  logic [TW-1:0] timer;
  logic          push, pop, dose_ok;

  function automatic logic [7:0] to_ml(input logic [3:0] t);
    logic [31:0] p;
    p = 32'(t) * 32'(ML_PER_TICK);
    return p > 32'd255 ? 8'hff : p[7:0];
  endfunction

  assign pedido_ready = nivel != (AW+1)'(DEPTH);
  assign push         = pedido_valid && pedido_ready && pedido_tipo != 2'd3;
  assign pop          = estado == OCIOSO && nivel != '0;
  assign head         = mem[rd_ptr];
  assign ocupado      = estado == SERVINDO || estado == PAUSA;
  assign exp_c        = atual == 2'd1 ? 4'd4 : 4'd2;
  assign exp_l        = atual == 2'd2 ? 4'd2 : 4'd0;
  assign dose_ok      = cafe_ticks == exp_c && leite_ticks == exp_l;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= pedido_tipo;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      nivel  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      nivel <= nivel + (AW+1)'(push) - (AW+1)'(pop);
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      estado         <= OCIOSO;
      atual          <= 2'd0;
      tipo           <= 2'd3;
      cafe_ticks     <= 4'd0;
      leite_ticks    <= 4'd0;
      timer          <= '0;
      entregue       <= 1'b0;
      erro           <= 1'b0;
      erro_codigo    <= 2'd0;
      ml_cafe        <= 8'd0;
      ml_leite       <= 8'd0;
      total_servidos <= 16'd0;
    end else begin
      entregue <= 1'b0;
      erro     <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (F) begin
            erro        <= 1'b1;
            erro_codigo <= 2'b11;
          end
          if (pop) begin
            atual       <= head;
            tipo        <= head;
            cafe_ticks  <= 4'd0;
            leite_ticks <= 4'd0;
            timer       <= '0;
            estado      <= SERVINDO;
          end
        end
        SERVINDO: begin
          if (F) begin
            ml_cafe  <= to_ml(cafe_ticks);
            ml_leite <= to_ml(leite_ticks);
            if (dose_ok) begin
              entregue       <= 1'b1;
              total_servidos <= total_servidos + 16'd1;
            end else begin
              erro        <= 1'b1;
              erro_codigo <= 2'b01;
            end
            tipo   <= 2'd3;
            estado <= PAUSA;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            erro        <= 1'b1;
            erro_codigo <= 2'b10;
            tipo        <= 2'd3;
            estado      <= PAUSA;
          end else begin
            timer       <= timer + 1'b1;
            cafe_ticks  <= cafe_ticks + 4'(C && cafe_ticks != 4'd15);
            leite_ticks <= leite_ticks + 4'(L && leite_ticks != 4'd15);
          end
        end
        PAUSA: begin
          if (F) begin
            erro        <= 1'b1;
            erro_codigo <= 2'b11;
          end
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
endmodule

// File: tb/tb_painel_de_pedidos.sv
// tb_painel_de_pedidos: directed tests against a behavioural coffee dispenser model
module tb_painel_de_pedidos;
  logic        clk = 1'b0, reset = 1'b1, pedido_valid = 1'b0;
  logic [1:0]  pedido_tipo = 2'd0;
  logic        pedido_ready, ocupado, entregue, erro, C, L, F;
  logic [1:0]  tipo, erro_codigo;
  logic [7:0]  ml_cafe, ml_leite;
  logic [15:0] total_servidos;
  logic [2:0]  nivel;
  int          checks = 0, failures = 0;
  // dispenser model: mode 0 normal, 1 short coffee dose, 2 never finishes
  logic [1:0]  mode = 2'd0;
  logic        f_force = 1'b0, d_run;
  logic [2:0]  d_c, d_l;

  painel_de_pedidos dut (
    .clk(clk), .reset(reset), .pedido_valid(pedido_valid), .pedido_tipo(pedido_tipo),
    .pedido_ready(pedido_ready), .tipo(tipo), .C(C), .L(L), .F(F), .ocupado(ocupado),
    .entregue(entregue), .erro(erro), .erro_codigo(erro_codigo), .ml_cafe(ml_cafe),
    .ml_leite(ml_leite), .total_servidos(total_servidos), .nivel(nivel)
  );

  always #5 clk = ~clk;

  assign C = d_run && d_c != 3'd0;
  assign L = d_run && d_c == 3'd0 && d_l != 3'd0;
  assign F = f_force || (d_run && d_c == 3'd0 && d_l == 3'd0 && mode != 2'd2);

  always @(posedge clk or negedge reset)
    if (!reset) begin
      d_run <= 1'b0;
      d_c   <= 3'd0;
      d_l   <= 3'd0;
    end else if (!d_run) begin
      if (tipo != 2'd3) begin
        d_run <= 1'b1;
        d_c   <= mode == 2'd1 ? 3'd1 : (tipo == 2'd1 ? 3'd4 : 3'd2);
        d_l   <= tipo == 2'd2 ? 3'd2 : 3'd0;
      end
    end else if (tipo == 2'd3) d_run <= 1'b0;
    else if (d_c != 3'd0) d_c <= d_c - 3'd1;
    else if (d_l != 3'd0) d_l <= d_l - 3'd1;
    else if (mode != 2'd2) d_run <= 1'b0;

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    pedido_valid = 1'b0;
    f_force = 1'b0;
    mode = 2'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (tipo !== 2'd3) begin failures++; $display("FAIL reset_tipo got=%0d exp=3", tipo); end
    checks++; if (pedido_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0d exp=1", pedido_ready); end
    checks++; if (nivel !== 3'd0) begin failures++; $display("FAIL reset_nivel got=%0d exp=0", nivel); end
    checks++; if ({ocupado, entregue, erro} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ocupado, entregue, erro}); end
    checks++; if ({erro_codigo, ml_cafe, ml_leite, total_servidos} !== 34'd0) begin failures++; $display("FAIL reset_regs got=%0h exp=0", {erro_codigo, ml_cafe, ml_leite, total_servidos}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_espresso;
    logic [1:0] et;
    apply_reset;
    pedido_valid = 1'b1;
    pedido_tipo = 2'd0;
    @(negedge clk);
    pedido_valid = 1'b0;
    checks++; if (nivel !== 3'd1 || tipo !== 2'd3) begin failures++; $display("FAIL esp_push got nivel=%0d tipo=%0d exp 1,3", nivel, tipo); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      et = k < 5 ? 2'd0 : 2'd3;
      checks++; if (tipo !== et) begin failures++; $display("FAIL esp_tipo c%0d got=%0d exp=%0d", k, tipo, et); end
      checks++; if (entregue !== (k == 5)) begin failures++; $display("FAIL esp_entregue c%0d got=%0d exp=%0d", k, entregue, k == 5); end
    end
    checks++; if (ml_cafe !== 8'd50 || ml_leite !== 8'd0) begin failures++; $display("FAIL esp_ml got=%0d/%0d exp=50/0", ml_cafe, ml_leite); end
    checks++; if (total_servidos !== 16'd1) begin failures++; $display("FAIL esp_total got=%0d exp=1", total_servidos); end
    @(negedge clk);
    checks++; if (entregue !== 1'b0 || ocupado !== 1'b0) begin failures++; $display("FAIL esp_after got=%0d%0d exp=00", entregue, ocupado); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] hist [40];
    logic [7:0] mc [2], mlt [2];
    int n = 0, last1 = -1, first2 = -1;
    apply_reset;
    pedido_valid = 1'b1;
    pedido_tipo = 2'd1;
    @(negedge clk);
    pedido_tipo = 2'd2;
    @(negedge clk);
    pedido_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hist[i] = tipo;
      if (entregue) begin
        if (n < 2) begin mc[n] = ml_cafe; mlt[n] = ml_leite; end
        n++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      if (hist[i] == 2'd1 && first2 < 0) last1 = i;
      if (hist[i] == 2'd2 && first2 < 0) first2 = i;
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", n); end
    if (n >= 2) begin
      checks++; if (mc[0] !== 8'd100 || mlt[0] !== 8'd0) begin failures++; $display("FAIL b2b_ml1 got=%0d/%0d exp=100/0", mc[0], mlt[0]); end
      checks++; if (mc[1] !== 8'd50 || mlt[1] !== 8'd50) begin failures++; $display("FAIL b2b_ml2 got=%0d/%0d exp=50/50", mc[1], mlt[1]); end
    end
    checks++; if (first2 - last1 - 1 !== 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=2", first2 - last1 - 1); end
    checks++; if (total_servidos !== 16'd2) begin failures++; $display("FAIL b2b_total got=%0d exp=2", total_servidos); end
  endtask

  task automatic test_fifo_full;
    int n = 0, maxn = 0;
    apply_reset;
    pedido_valid = 1'b1;
    pedido_tipo = 2'd0;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (entregue) n++;
      checks++; if (nivel !== 3'(k < 4 ? k : 4)) begin failures++; $display("FAIL full_nivel c%0d got=%0d exp=%0d", k, nivel, k < 4 ? k : 4); end
      checks++; if (pedido_ready !== (k < 4)) begin failures++; $display("FAIL full_ready c%0d got=%0d exp=%0d", k, pedido_ready, k < 4); end
    end
    pedido_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (entregue) n++;
      if (int'(nivel) > maxn) maxn = int'(nivel);
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL full_entregues got=%0d exp=5", n); end
    checks++; if (maxn > 4) begin failures++; $display("FAIL full_max_nivel got=%0d exp<=4", maxn); end
    checks++; if (nivel !== 3'd0 || total_servidos !== 16'd5) begin failures++; $display("FAIL full_end got nivel=%0d total=%0d exp 0,5", nivel, total_servidos); end
  endtask

  task automatic test_short_dose;
    int ok = 0, n = 0;
    apply_reset;
    mode = 2'd1;
    pedido_valid = 1'b1;
    pedido_tipo = 2'd0;
    @(negedge clk);
    pedido_valid = 1'b0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge clk);
      if (entregue) n++;
      if (erro) ok = 1;
    end
    checks++; if (ok !== 1) begin failures++; $display("FAIL short_erro got=%0d exp=1", ok); end
    checks++; if (erro_codigo !== 2'b01) begin failures++; $display("FAIL short_code got=%0d exp=1", erro_codigo); end
    checks++; if (ml_cafe !== 8'd25 || ml_leite !== 8'd0) begin failures++; $display("FAIL short_ml got=%0d/%0d exp=25/0", ml_cafe, ml_leite); end
    checks++; if (total_servidos !== 16'd0 || n !== 0) begin failures++; $display("FAIL short_total got=%0d/%0d exp=0/0", total_servidos, n); end
    mode = 2'd0;
  endtask

  task automatic test_timeout;
    int early = 0, ok = 0;
    apply_reset;
    mode = 2'd2;
    pedido_valid = 1'b1;
    pedido_tipo = 2'd0;
    @(negedge clk);
    pedido_tipo = 2'd1;
    @(negedge clk);
    pedido_valid = 1'b0;
    checks++; if (nivel !== 3'd1 || tipo !== 2'd0) begin failures++; $display("FAIL to_start got nivel=%0d tipo=%0d exp 1,0", nivel, tipo); end
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      if (k < 17 && erro) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL to_early got=%0d exp=0", early); end
    checks++; if (erro !== 1'b1 || erro_codigo !== 2'b10) begin failures++; $display("FAIL to_erro got=%0d code=%0d exp 1,2", erro, erro_codigo); end
    checks++; if (tipo !== 2'd3) begin failures++; $display("FAIL to_tipo got=%0d exp=3", tipo); end
    @(negedge clk);
    mode = 2'd0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      @(negedge clk);
      if (entregue) ok = 1;
    end
    checks++; if (ok !== 1) begin failures++; $display("FAIL to_next_served got=%0d exp=1", ok); end
    checks++; if (ml_cafe !== 8'd100 || total_servidos !== 16'd1 || erro_codigo !== 2'b10) begin failures++; $display("FAIL to_next got ml=%0d total=%0d code=%0d exp 100,1,2", ml_cafe, total_servidos, erro_codigo); end
  endtask

  task automatic test_misc;
    apply_reset;
    pedido_valid = 1'b1;
    pedido_tipo = 2'd3;
    @(negedge clk);
    pedido_valid = 1'b0;
    checks++; if (nivel !== 3'd0 || tipo !== 2'd3 || erro !== 1'b0) begin failures++; $display("FAIL inv_drop got nivel=%0d tipo=%0d erro=%0d exp 0,3,0", nivel, tipo, erro); end
    f_force = 1'b1;
    @(negedge clk);
    f_force = 1'b0;
    checks++; if (erro !== 1'b1 || erro_codigo !== 2'b11) begin failures++; $display("FAIL spur_f got erro=%0d code=%0d exp 1,3", erro, erro_codigo); end
    @(negedge clk);
    checks++; if (erro !== 1'b0) begin failures++; $display("FAIL spur_pulse got=%0d exp=0", erro); end
    pedido_valid = 1'b1;
    pedido_tipo = 2'd1;
    @(negedge clk);
    pedido_tipo = 2'd2;
    @(negedge clk);
    pedido_valid = 1'b0;
    @(negedge clk);
    checks++; if (ocupado !== 1'b1 || nivel !== 3'd1 || tipo !== 2'd1) begin failures++; $display("FAIL mid_state got ocup=%0d nivel=%0d tipo=%0d exp 1,1,1", ocupado, nivel, tipo); end
    #2 reset = 1'b0;
    #1;
    checks++; if (tipo !== 2'd3 || nivel !== 3'd0 || ocupado !== 1'b0 || pedido_ready !== 1'b1) begin failures++; $display("FAIL async_reset got tipo=%0d nivel=%0d ocup=%0d ready=%0d exp 3,0,0,1", tipo, nivel, ocupado, pedido_ready); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset;
    test_espresso;
    test_back_to_back;
    test_fifo_full;
    test_short_dose;
    test_timeout;
    test_misc;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
